// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V controller.
//   statetype : controller FSM states
//   ALUOP_*   : ALUOp encodings passed from the main FSM to aludec
//   OP_*      : instruction opcodes recognised by the controller
//   ALU_*     : ALUControl encodings produced by aludec
//   branch_taken() : branch condition from funct3 and datapath flags
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL
    } statetype;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // beq/bne use Zero from a subtract; blt/bge use the signed >= flag.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zero,
                                          input logic       ge);
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = ~zero;
            3'b100:  branch_taken = ~ge;
            3'b101:  branch_taken = ge;
            default: branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps ALUOp plus instruction fields to an ALU operation.
//   ALUOp      in  [1:0] operation class from the main FSM
//   funct3     in  [2:0] instruction funct3
//   funct7b5   in        instruction bit 30
//   opb5       in        opcode bit 5 (1 = R-type, 0 = I-type)
//   ALUControl out [2:0] ALU operation select
module aludec
    import riscv_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       opb5,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 only means subtract on R-type; on addi it is immediate bit.
                    3'b000:  ALUControl = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V controller: Moore FSM sequencing fetch, decode,
// memory, ALU, branch and jal steps, with combinational datapath selects.
//   clk, reset        : clock, synchronous active-high reset
//   op, funct3, funct7b5 : instruction fields
//   Zero, emaior      : branch flags (ALU zero, signed rs1 >= rs2)
//   MemReady          : memory access completes this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal : strobes/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc : datapath mux selects
//   ALUControl        : ALU operation
module mc_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       emaior,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic       Illegal
);

    statetype   state_q, state_d;
    logic [1:0] alu_op;
    logic       pc_update, branch, mem_write, ir_write, reg_write, illegal;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWRITE: if (MemReady) state_d = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ResultSrc = 2'b10;
                ALUSrcB   = 2'b10;
                ir_write  = MemReady;
                pc_update = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                illegal = !(op inside {OP_LOAD, OP_STORE, OP_RTYPE,
                                       OP_ITYPE, OP_BRANCH, OP_JAL});
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are forced low while reset is held so nothing is committed.
    always_comb begin
        PCWrite  = !reset && (pc_update || (branch && branch_taken(funct3, Zero, emaior)));
        MemWrite = !reset && mem_write;
        IRWrite  = !reset && ir_write;
        RegWrite = !reset && reg_write;
        Illegal  = !reset && illegal;
    end

    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    aludec u_aludec (
        .ALUOp      (alu_op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .opb5       (op[5]),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'h00;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0, Zero = 1'b0, emaior = 1'b0, MemReady = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .emaior(emaior), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .ALUControl(ALUControl), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    // Packed expectation: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,Illegal,
    //                      ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl}
    typedef struct {
        string       name;
        logic [16:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;

    function automatic logic [16:0] ev(input bit pcw, input bit adr, input bit mw,
                                       input bit irw, input bit rw, input bit ill,
                                       input bit [1:0] rs, input bit [1:0] sa,
                                       input bit [1:0] sb, input bit [1:0] imm,
                                       input bit [2:0] alu);
        return {pcw, adr, mw, irw, rw, ill, rs, sa, sb, imm, alu};
    endfunction

    // One cycle: drive inputs just after the edge and queue the expected outputs.
    task automatic step(input string nm, input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic z, input logic ge,
                        input logic mr, input logic rst, input logic [16:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; emaior = ge;
        MemReady = mr; reset = rst;
        x.name = nm;
        x.exp  = e;
        q.push_back(x);
    endtask

    // Monitor: outputs are presented every cycle, sampled on the falling edge.
    initial begin
        exp_t x;
        logic [16:0] got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal,
                       ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
                checks++;
                if (got !== x.exp) begin
                    failures++;
                    $display("FAIL %s got=%05h exp=%05h", x.name, got, x.exp);
                end
            end
        end
    end

    localparam logic [6:0] LW = 7'h03, SW = 7'h23, RT = 7'h33, IT = 7'h13,
                           BR = 7'h63, JL = 7'h6F, BAD = 7'h7F;

    initial begin
        // Reset: FETCH selects visible, every strobe low even with MemReady high.
        step("rst0",    RT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ev(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000));
        step("rst1",    RT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ev(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000));
        // add x3,x1,x2
        step("add.F",   RT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000));
        step("add.D",   RT, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000));
        step("add.X",   RT, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000));
        step("add.WB",  RT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000));
        // sub: R-type with funct7b5 set
        step("sub.F",   RT, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000));
        step("sub.D",   RT, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000));
        step("sub.X",   RT, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001));
        step("sub.WB",  RT, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000));
        // addi with bit30 set must still add; ori/andi/slti through EXECUTEI
        step("addi.F",  IT, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000));
        step("addi.D",  IT, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000));
        step("addi.X",  IT, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000));
        step("addi.WB", IT, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000));
        step("ori.F",   IT, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000));
        step("ori.D",   IT, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000));
        step("ori.X",   IT, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b011));
        step("ori.WB",  IT, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000));
        step("andi.F",  IT, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000));
        step("andi.D",  IT, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000));
        step("andi.X",  IT, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b010));
        step("andi.WB", IT, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000));
        step("slti.F",  IT, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000));
        step("slti.D",  IT, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000));
        step("slti.X",  IT, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b101));
        step("slti.WB", IT, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000));
        // lw: fetch stall, then MEMREAD held 4 cycles
        step("lw.Fw",   LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000));
        step("lw.F",    LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000));
        step("lw.D",    LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000));
        step("lw.A",    LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000));
        for (int i = 0; i < 3; i++)
            step("lw.Rw", LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000));
        step("lw.R",    LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000));
        step("lw.WB",   LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,1,0,2'b01,2'b00,2'b00,2'b00,3'b000));
        // blt (emaior=0) taken
        step("blt.F",   BR, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b10,3'b000));
        step("blt.D",   BR, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000));
        step("blt.B",   BR, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001));
        // bge (emaior=0) not taken
        step("bge.F",   BR, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b10,3'b000));
        step("bge.D",   BR, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000));
        step("bge.B",   BR, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001));
        // bne with Zero=1 not taken
        step("bne.F",   BR, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b10,3'b000));
        step("bne.D",   BR, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000));
        step("bne.B",   BR, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001));
        // beq with Zero=1 taken; unsupported funct3 never taken
        step("beq.F",   BR, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b10,3'b000));
        step("beq.D",   BR, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000));
        step("beq.B",   BR, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ev(1,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001));
        step("b3.F",    BR, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b10,3'b000));
        step("b3.D",    BR, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000));
        step("b3.B",    BR, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001));
        // sw: MemWrite held 3 cycles
        step("sw.F",    SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b01,3'b000));
        step("sw.D",    SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000));
        step("sw.A",    SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000));
        for (int i = 0; i < 2; i++)
            step("sw.Ww", SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,1,1,0,0,0,2'b00,2'b00,2'b00,2'b01,3'b000));
        step("sw.W",    SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,1,1,0,0,0,2'b00,2'b00,2'b00,2'b01,3'b000));
        // jal
        step("jal.F",   JL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b11,3'b000));
        step("jal.D",   JL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000));
        step("jal.J",   JL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(1,0,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000));
        step("jal.WB",  JL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b11,3'b000));
        // illegal opcode: pulse in DECODE, back to FETCH
        step("bad.F",   BAD, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000));
        step("bad.D",   BAD, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,1,2'b00,2'b01,2'b01,2'b00,3'b000));
        step("bad.F2",  BAD, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000));
        // reset during MEMREAD wait
        step("rlw.F",   LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000));
        step("rlw.D",   LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000));
        step("rlw.A",   LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000));
        step("rlw.Rw",  LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000));
        step("rlw.Rr",  LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ev(0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000));
        step("rlw.Fr",  LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ev(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000));
        step("rlw.F2",  LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000));
        // reset during MEMWRITE wait: MemWrite must drop
        step("rsw.D",   SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000));
        step("rsw.A",   SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000));
        step("rsw.Wr",  SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ev(0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b01,3'b000));
        step("rsw.F",   SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,0,0,2'b10,2'b00,2'b10,2'b01,3'b000));
        @(posedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have port op, input, 7, opcode from instruction register.
REQ-004 SHALL have port funct3, input, 3, instruction funct3.
REQ-005 SHALL have port funct7b5, input, 1, instruction bit 30.
REQ-006 SHALL have port Zero, input, 1, ALU result equals zero.
REQ-007 SHALL have port emaior, input, 1, signed rs1 >= rs2 flag from datapath.
REQ-008 SHALL have port MemReady, input, 1, memory access complete this cycle.
REQ-009 SHALL have port PCWrite, output, 1, PC register enable.
REQ-010 SHALL have port AdrSrc, output, 1, memory address select (0 PC, 1 ALUOut).
REQ-011 SHALL have port MemWrite, output, 1, data memory write strobe.
REQ-012 SHALL have port IRWrite, output, 1, instruction register / OldPC enable.
REQ-013 SHALL have ports ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, outputs, 2 each, datapath mux selects.
REQ-014 SHALL have port RegWrite, output, 1, register file write enable.
REQ-015 SHALL have port ALUControl, output, 3, ALU operation.
REQ-016 SHALL have port Illegal, output, 1, one-cycle pulse on unsupported opcode.

Function
REQ-017 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL.
REQ-018 Transitions SHALL be: FETCH->DECODE when MemReady, else hold; DECODE->MEMADR (op 0000011/0100011), EXECUTER (0110011), EXECUTEI (0010011), BRANCH (1100011), JAL (1101111), FETCH otherwise with Illegal=1 for that cycle; MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB when MemReady, else hold; MEMWRITE->FETCH when MemReady, else hold; EXECUTER/EXECUTEI->ALUWB; JAL->ALUWB; MEMWB, ALUWB, BRANCH->FETCH.
REQ-019 Per-state selects (ALUSrcA/ALUSrcB/ResultSrc/ALUOp): FETCH 00/10/10/00, AdrSrc=0; DECODE 01/01/--/00; MEMADR 10/01/--/00; MEMREAD --/--/00/--, AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1; MEMWRITE ResultSrc=00, AdrSrc=1, MemWrite=1; EXECUTER 10/00/--/10; EXECUTEI 10/01/--/10; ALUWB ResultSrc=00, RegWrite=1; BRANCH 10/00/00/01; JAL 01/10/00/00. Unlisted selects SHALL be 0.
REQ-020 IRWrite and FETCH PCUpdate SHALL assert only in the FETCH cycle where MemReady=1; JAL SHALL assert PCUpdate unconditionally.
REQ-021 MemWrite SHALL stay asserted every MEMWRITE cycle until MemReady completes the access.
REQ-022 PCWrite SHALL equal PCUpdate OR (state==BRANCH AND taken); taken: funct3 000 Zero, 001 !Zero, 100 !emaior, 101 emaior, other funct3 never taken.
REQ-023 ImmSrc SHALL decode combinationally from op: 0000011/0010011 00, 0100011 01, 1100011 10, 1101111 11, others 00.
REQ-024 ALUControl SHALL derive combinationally from ALUOp, funct3, funct7b5, op[5] (00 add 000, 01 sub 001, 10 per funct3: add/sub 000/001 with sub only for R-type funct7b5=1, slt 101, or 011, and 010).
REQ-025 Branch comparison flags SHALL be sampled only in BRANCH; Zero/emaior are ignored in all other states.

Reset
REQ-026 reset=1 at a rising edge SHALL force state to FETCH regardless of current state, including mid-wait in MEMREAD/MEMWRITE.
REQ-027 While reset is asserted all strobes (PCWrite, IRWrite, MemWrite, RegWrite, Illegal) SHALL be 0; first FETCH fetch occurs the cycle after reset deasserts.

Structure
REQ-028 State enum, ALUOp encodings and opcode constants SHALL reside in shared package riscv_pkg.
REQ-029 ALU decode SHALL be the existing aludec sub-module, instantiated once; next-state and output logic live in mc_controller.

Verification
REQ-030 add x3,x1,x2 with MemReady=1 -> FETCH,DECODE,EXECUTER,ALUWB; ALUControl=000 in EXECUTER, RegWrite=1 only in ALUWB (4 cycles).
REQ-031 lw with MemReady low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, MEMWB once, RegWrite=1 with ResultSrc=01.
REQ-032 blt with emaior=0, then bge with emaior=0 -> PCWrite=1 in BRANCH for blt, 0 for bge; bne with Zero=1 -> PCWrite=0.
REQ-033 sw with MemReady low 2 cycles -> MemWrite=1 for 3 consecutive cycles, AdrSrc=1, then FETCH.
REQ-034 op=1111111 -> Illegal=1 for one cycle in DECODE, return to FETCH, no RegWrite/MemWrite.
REQ-035 reset asserted during MEMREAD wait -> FETCH next cycle, all strobes 0 while reset high.
